i2c_master_core: RTL and testbench

- Single-master I2C bus controller.
- Generates START, sends a 7-bit address plus R/W bit, then either writes bytes from `w_data` or reads bytes from the bus, and ends with STOP.
- Sits between local control logic (start/stop/rw/addr/data strobes) and the open-drain I2C pins; SCL is derived from the system clock.

---
 rtl/i2c_master_core.sv | 162 ++++++++++++++++
 tb/tb_i2c_master_core.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_core.sv
// Single-master I2C controller: START, 7-bit address + R/W, byte writes or
// reads with ACK handling, then STOP. SCL is derived from clk in 4 phases of QTR cycles.
module i2c_master_core #(
  parameter int QTR = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] w_data,
  output logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] r_data,
  output logic       r_valid,
  output logic       busy,
  output logic       ack_error
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
    S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
  } state_e;

  state_e        state, state_nx;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh, rx_sh, wbyte;
  logic          rw_q, samp_hi, mack, sda_low;
  logic          qtick, samp_now, cell_end, cell_scl;

  // Anything other than a solid low on the bus (1, z, x) reads as released.
  function automatic logic bus_released(input logic v);
    if (v == 1'b0) return 1'b0;
    else           return 1'b1;
  endfunction

  assign qtick    = (state != S_IDLE) && (qcnt == QW'(QTR - 1));
  assign samp_now = qtick && (phase == 2'd2);
  assign cell_end = qtick && (phase == 2'd3);
  assign cell_scl = phase[0] ^ phase[1];
  assign busy     = (state != S_IDLE);
  assign i2c_sda  = sda_low ? 1'b0 : 1'bz;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and bus pin levels per state/phase.
  always_comb begin
    state_nx = state;
    i2c_scl  = 1'b1;
    sda_low  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_START;
      S_START: begin
        i2c_scl = (phase != 2'd3);
        sda_low = phase[1];
        if (cell_end) state_nx = S_ADDR;
      end
      S_ADDR, S_WRITE: begin
        i2c_scl = cell_scl;
        sda_low = ~tx_sh[7];
        if (cell_end && bit_cnt == 3'd7)
          state_nx = (state == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
      end
      S_ADDR_ACK: begin
        i2c_scl = cell_scl;
        if (cell_end) state_nx = samp_hi ? S_STOP : (rw_q ? S_READ : S_WRITE);
      end
      S_WRITE_ACK: begin
        i2c_scl = cell_scl;
        if (cell_end) state_nx = (samp_hi || stop || !start) ? S_STOP : S_WRITE;
      end
      S_READ: begin
        i2c_scl = cell_scl;
        if (cell_end && bit_cnt == 3'd7) state_nx = S_READ_ACK;
      end
      S_READ_ACK: begin
        i2c_scl = cell_scl;
        sda_low = mack;
        if (cell_end) state_nx = mack ? S_READ : S_STOP;
      end
      S_STOP: begin
        i2c_scl = (phase != 2'd0);
        sda_low = ~phase[1];
        if (cell_end) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Phase timing, bit counting, status flags and read-data output.
  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt      <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      ack_error <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_valid <= 1'b0;
      if (state == S_IDLE) begin
        qcnt    <= '0;
        phase   <= 2'd0;
        bit_cnt <= 3'd0;
        if (start) ack_error <= 1'b0;
      end else begin
        if (qtick) begin
          qcnt  <= '0;
          phase <= phase + 2'd1;
        end else begin
          qcnt <= qcnt + QW'(1);
        end
        if (cell_end) begin
          case (state)
            S_ADDR, S_WRITE: bit_cnt <= bit_cnt + 3'd1;
            S_ADDR_ACK, S_WRITE_ACK: if (samp_hi) ack_error <= 1'b1;
            S_READ: begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                r_data  <= {rx_sh[6:0], samp_hi};
                r_valid <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Shift registers, latched request fields and the SDA sample.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      tx_sh <= {addr, rw};
      rw_q  <= rw;
      wbyte <= w_data;
    end
    if (samp_now) samp_hi <= bus_released(i2c_sda);
    if (cell_end) begin
      case (state)
        S_ADDR, S_WRITE: tx_sh <= {tx_sh[6:0], 1'b0};
        S_ADDR_ACK:      if (!rw_q) tx_sh <= wbyte;
        S_WRITE_ACK:     tx_sh <= w_data;
        S_READ: begin
          rx_sh <= {rx_sh[6:0], samp_hi};
          if (bit_cnt == 3'd7) mack <= !stop && start;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: a bus-level monitor decodes START/STOP/bytes/ACKs
// from the pins, a slave model ACKs and serves read bytes, and each test
// compares the decoded transaction against what the request should produce.
module tb_i2c_master_core;
  localparam int QTR = 1;

  logic       clk = 1'b0;
  logic       reset, start, stop, rw;
  logic [6:0] addr;
  logic [7:0] w_data;
  logic       i2c_scl;
  wire        sda;
  logic [7:0] r_data;
  logic       r_valid, busy, ack_error;

  logic slave_low = 1'b0;
  logic slave_ack_en = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_core #(.QTR(QTR)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .rw(rw),
    .addr(addr), .w_data(w_data), .i2c_scl(i2c_scl), .i2c_sda(sda),
    .r_data(r_data), .r_valid(r_valid), .busy(busy), .ack_error(ack_error)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] wr_bytes[8];
  logic [7:0] rd_bytes[8];

  // Monitor / slave state
  logic [7:0] mon_b[$];
  logic       mon_a[$];
  logic [7:0] rq[$];
  int   start_cnt = 0, stop_cnt = 0, busy_cnt = 0, rv_multi = 0;
  int   m_bit = 0, m_byte = 0;
  logic m_dir = 1'b0, m_done = 1'b0, p_scl = 1'b1, p_sda = 1'b1, prev_rv = 1'b0;
  logic [7:0] m_cur = 8'h00;
  logic sda_now;

  // Bus decoder plus ACKing slave; slave changes SDA only after SCL falls.
  always @(negedge clk) begin
    sda_now = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (busy === 1'b1) busy_cnt++;
    if (r_valid === 1'b1) begin
      rq.push_back(r_data);
      if (prev_rv) rv_multi++;
    end
    prev_rv = (r_valid === 1'b1);
    if (i2c_scl && p_scl && p_sda && !sda_now) begin
      start_cnt++;
      m_bit = 0; m_byte = 0; m_done = 1'b0; slave_low = 1'b0;
    end else if (i2c_scl && p_scl && !p_sda && sda_now) begin
      stop_cnt++;
      slave_low = 1'b0;
    end else if (i2c_scl && !p_scl) begin
      if (m_bit < 8) begin
        m_cur = {m_cur[6:0], sda_now};
        m_bit++;
      end else begin
        mon_b.push_back(m_cur);
        mon_a.push_back(sda_now);
        if (m_byte == 0) m_dir = m_cur[0];
        if (sda_now) m_done = 1'b1;
        m_bit = 0;
        m_byte++;
      end
    end else if (!i2c_scl && p_scl) begin
      if (m_bit == 8)
        slave_low = slave_ack_en && !m_done && (m_byte == 0 || !m_dir);
      else if (m_dir && m_byte > 0 && m_byte <= 8 && !m_done)
        slave_low = !rd_bytes[m_byte-1][7-m_bit];
      else
        slave_low = 1'b0;
    end
    p_scl = i2c_scl;
    p_sda = sda_now;
  end

  // Drives one complete transaction request and reports counter snapshots.
  task automatic run_txn(input logic rwb, input logic [6:0] a, input int n,
                         input logic early_stop, input logic ack_en,
                         output int b0, output int r0, output int st0, output int sp0,
                         output int bz0, output int rvm0, output logic timed_out);
    int ev, ev_seen, rv;
    b0 = mon_b.size(); r0 = rq.size(); st0 = start_cnt; sp0 = stop_cnt;
    bz0 = busy_cnt; rvm0 = rv_multi;
    timed_out = 1'b1;
    ev_seen = 0;
    slave_ack_en = ack_en;
    rw = rwb; addr = a; w_data = wr_bytes[0];
    stop = rwb && (n == 1);
    start = 1'b1;
    @(posedge clk); #1;
    w_data = ~wr_bytes[0];
    for (int cyc = 1; cyc < 4*QTR*9*(n+3); cyc++) begin
      if (busy == 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      if (early_stop && cyc == 30) stop = 1'b1;
      ev = mon_b.size() - b0;
      if (!rwb && ev != ev_seen) begin
        ev_seen = ev;
        if (ev - 1 >= 1 && ev - 1 < n) w_data = wr_bytes[ev-1];
        if (ev - 1 == n) stop = 1'b1;
      end
      rv = rq.size() - r0;
      if (rwb && n >= 2 && rv == n - 1) stop = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; rw = 1'b0; addr = '0; w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (i2c_scl !== 1'b1) begin bad++; $display("FAIL reset_scl: got %b want 1", i2c_scl); end
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want released(1)", sda); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (ack_error !== 1'b0) begin bad++; $display("FAIL reset_ack_error: got %b want 0", ack_error); end
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
    total++; if (r_data !== 8'h00) begin bad++; $display("FAIL reset_r_data: got %h want 00", r_data); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_noack();
    int b0, r0, st0, sp0, bz0, rvm0; logic to;
    wr_bytes[0] = 8'hAA;
    run_txn(1'b0, 7'h55, 1, 1'b0, 1'b0, b0, r0, st0, sp0, bz0, rvm0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL noack_timeout: got %b want 0", to); end
    total++; if (busy_cnt - bz0 != 44) begin bad++; $display("FAIL noack_busy_len: got %0d want 44", busy_cnt - bz0); end
    total++; if (mon_b.size() - b0 != 1) begin bad++; $display("FAIL noack_nbytes: got %0d want 1", mon_b.size() - b0); end
    if (mon_b.size() > b0) begin
      total++; if (mon_b[b0] !== 8'hAA) begin bad++; $display("FAIL noack_addr_byte: got %h want aa", mon_b[b0]); end
      total++; if (mon_a[b0] !== 1'b1) begin bad++; $display("FAIL noack_ack_bit: got %b want 1", mon_a[b0]); end
    end
    total++; if (ack_error !== 1'b1) begin bad++; $display("FAIL noack_ack_error: got %b want 1", ack_error); end
    total++; if (start_cnt - st0 != 1 || stop_cnt - sp0 != 1) begin
      bad++; $display("FAIL noack_start_stop: got %0d/%0d want 1/1", start_cnt - st0, stop_cnt - sp0); end
  endtask

  task automatic test_write_ack();
    int b0, r0, st0, sp0, bz0, rvm0; logic to;
    logic [7:0] eb[2];
    eb[0] = 8'hAA; eb[1] = 8'hAA;
    wr_bytes[0] = 8'hAA;
    run_txn(1'b0, 7'h55, 1, 1'b1, 1'b1, b0, r0, st0, sp0, bz0, rvm0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL wack_timeout: got %b want 0", to); end
    total++; if (busy_cnt - bz0 != 80) begin bad++; $display("FAIL wack_busy_len: got %0d want 80", busy_cnt - bz0); end
    total++; if (mon_b.size() - b0 != 2) begin bad++; $display("FAIL wack_nbytes: got %0d want 2", mon_b.size() - b0); end
    for (int i = 0; i < 2 && b0 + i < mon_b.size(); i++) begin
      total++; if (mon_b[b0+i] !== eb[i] || mon_a[b0+i] !== 1'b0) begin
        bad++; $display("FAIL wack_byte%0d: got %h/ack%b want %h/ack0", i, mon_b[b0+i], mon_a[b0+i], eb[i]); end
    end
    total++; if (ack_error !== 1'b0) begin bad++; $display("FAIL wack_ack_error: got %b want 0", ack_error); end
    total++; if (stop_cnt - sp0 != 1) begin bad++; $display("FAIL wack_stop: got %0d want 1", stop_cnt - sp0); end
  endtask

  task automatic test_multi_write();
    int b0, r0, st0, sp0, bz0, rvm0; logic to;
    logic [7:0] eb[3];
    eb[0] = 8'hAA; eb[1] = 8'hAA; eb[2] = 8'h3C;
    wr_bytes[0] = 8'hAA; wr_bytes[1] = 8'h3C;
    run_txn(1'b0, 7'h55, 2, 1'b0, 1'b1, b0, r0, st0, sp0, bz0, rvm0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL multi_timeout: got %b want 0", to); end
    total++; if (busy_cnt - bz0 != 116) begin bad++; $display("FAIL multi_busy_len: got %0d want 116", busy_cnt - bz0); end
    total++; if (mon_b.size() - b0 != 3) begin bad++; $display("FAIL multi_nbytes: got %0d want 3", mon_b.size() - b0); end
    for (int i = 0; i < 3 && b0 + i < mon_b.size(); i++) begin
      total++; if (mon_b[b0+i] !== eb[i] || mon_a[b0+i] !== 1'b0) begin
        bad++; $display("FAIL multi_byte%0d: got %h/ack%b want %h/ack0", i, mon_b[b0+i], mon_a[b0+i], eb[i]); end
    end
    total++; if (ack_error !== 1'b0) begin bad++; $display("FAIL multi_ack_error: got %b want 0", ack_error); end
  endtask

  task automatic test_read();
    int b0, r0, st0, sp0, bz0, rvm0; logic to;
    rd_bytes[0] = 8'h01;
    run_txn(1'b1, 7'h55, 1, 1'b0, 1'b1, b0, r0, st0, sp0, bz0, rvm0, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL read_timeout: got %b want 0", to); end
    total++; if (busy_cnt - bz0 != 80) begin bad++; $display("FAIL read_busy_len: got %0d want 80", busy_cnt - bz0); end
    total++; if (mon_b.size() - b0 != 2) begin bad++; $display("FAIL read_nbytes: got %0d want 2", mon_b.size() - b0); end
    if (mon_b.size() >= b0 + 2) begin
      total++; if (mon_b[b0] !== 8'hAB || mon_a[b0] !== 1'b0) begin
        bad++; $display("FAIL read_addr_byte: got %h/ack%b want ab/ack0", mon_b[b0], mon_a[b0]); end
      total++; if (mon_a[b0+1] !== 1'b1) begin bad++; $display("FAIL read_master_nack: got %b want 1", mon_a[b0+1]); end
    end
    total++; if (rq.size() - r0 != 1) begin bad++; $display("FAIL read_rvalid_count: got %0d want 1", rq.size() - r0); end
    if (rq.size() > r0) begin
      total++; if (rq[r0] !== 8'h01) begin bad++; $display("FAIL read_r_data: got %h want 01", rq[r0]); end
    end
    total++; if (rv_multi - rvm0 != 0) begin bad++; $display("FAIL read_rvalid_pulse: got %0d long pulses want 0", rv_multi - rvm0); end
  endtask

  task automatic test_random();
    int b0, r0, st0, sp0, bz0, rvm0, n; logic to, rwb; logic [6:0] a;
    logic [7:0] eb[$];
    for (int it = 0; it < 8; it++) begin
      rwb = 1'($urandom_range(0, 1));
      a   = 7'($urandom);
      n   = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        wr_bytes[i] = 8'($urandom);
        rd_bytes[i] = 8'($urandom);
      end
      run_txn(rwb, a, n, 1'b0, 1'b1, b0, r0, st0, sp0, bz0, rvm0, to);
      eb = {};
      eb.push_back({a, rwb});
      for (int i = 0; i < n; i++) eb.push_back(rwb ? rd_bytes[i] : wr_bytes[i]);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL rand%0d_timeout: got %b want 0", it, to); end
      total++; if (busy_cnt - bz0 != 4*QTR*(2 + 9*(n+1))) begin
        bad++; $display("FAIL rand%0d_busy_len: got %0d want %0d", it, busy_cnt - bz0, 4*QTR*(2 + 9*(n+1))); end
      total++; if (mon_b.size() - b0 != n + 1) begin
        bad++; $display("FAIL rand%0d_nbytes: got %0d want %0d", it, mon_b.size() - b0, n + 1); end
      for (int i = 0; i <= n && b0 + i < mon_b.size(); i++) begin
        total++; if (mon_b[b0+i] !== eb[i] || mon_a[b0+i] !== (rwb && i == n)) begin
          bad++; $display("FAIL rand%0d_byte%0d: got %h/ack%b want %h/ack%b", it, i,
                          mon_b[b0+i], mon_a[b0+i], eb[i], (rwb && i == n)); end
      end
      if (rwb) begin
        total++; if (rq.size() - r0 != n) begin bad++; $display("FAIL rand%0d_rvalid_count: got %0d want %0d", it, rq.size() - r0, n); end
        for (int i = 0; i < n && r0 + i < rq.size(); i++) begin
          total++; if (rq[r0+i] !== rd_bytes[i]) begin bad++; $display("FAIL rand%0d_r_data%0d: got %h want %h", it, i, rq[r0+i], rd_bytes[i]); end
        end
        total++; if (rv_multi - rvm0 != 0) begin bad++; $display("FAIL rand%0d_rvalid_pulse: got %0d want 0", it, rv_multi - rvm0); end
      end
      total++; if (ack_error !== 1'b0 || start_cnt - st0 != 1 || stop_cnt - sp0 != 1) begin
        bad++; $display("FAIL rand%0d_status: got err%b start%0d stop%0d want err0 start1 stop1",
                        it, ack_error, start_cnt - st0, stop_cnt - sp0); end
    end
  endtask

  task automatic test_reset_mid();
    int b0, r0, st0, sp0, bz0, rvm0, cyc; logic to; logic [6:0] a2;
    slave_ack_en = 1'b1;
    rw = 1'b0; addr = 7'($urandom); w_data = 8'($urandom); stop = 1'b0; start = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_before_edge: got %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_rise: got %b want 1", busy); end
    cyc = 0;
    while (m_bit != 5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (m_bit != 5) begin bad++; $display("FAIL mid_reach_bit4: got %0d bits want 5", m_bit); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (i2c_scl !== 1'b1) begin bad++; $display("FAIL mid_scl: got %b want 1", i2c_scl); end
    total++; if (sda !== 1'b1) begin bad++; $display("FAIL mid_sda: got %b want released(1)", sda); end
    @(posedge clk); #1;
    a2 = 7'($urandom);
    wr_bytes[0] = 8'($urandom);
    run_txn(1'b0, a2, 1, 1'b0, 1'b1, b0, r0, st0, sp0, bz0, rvm0, to);
    total++; if (to !== 1'b0 || start_cnt - st0 != 1) begin
      bad++; $display("FAIL mid_restart: got timeout%b starts%0d want timeout0 starts1", to, start_cnt - st0); end
    total++; if (mon_b.size() - b0 != 2) begin bad++; $display("FAIL mid_nbytes: got %0d want 2", mon_b.size() - b0); end
    if (mon_b.size() >= b0 + 2) begin
      total++; if (mon_b[b0] !== {a2, 1'b0} || mon_b[b0+1] !== wr_bytes[0]) begin
        bad++; $display("FAIL mid_bytes: got %h %h want %h %h", mon_b[b0], mon_b[b0+1], {a2, 1'b0}, wr_bytes[0]); end
    end
    total++; if (busy_cnt - bz0 != 80) begin bad++; $display("FAIL mid_busy_len: got %0d want 80", busy_cnt - bz0); end
  endtask

  initial begin
    test_reset();
    test_write_noack();
    test_write_ack();
    test_multi_write();
    test_read();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
